lsu: RTL and testbench

Load/store unit between the EX/MEM pipeline register and `dcache`. It converts RV32I load/store requests (LB/LH/LW/LBU/LHU/SB/SH/SW) into word-granular cache transactions, holds the `rd`/`wr` handshake until `data_ready`, and extracts and sign-extends load data. Sub-word stores are done as read-modify-write, because the cache overwrites whole words. The block stalls the pipeline for the full duration of each access.

---
 rtl/lsu.sv | 203 ++++++++++++++++++++
 tb/tb_lsu.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu.sv
// Load/store unit: turns RV32I loads/stores into word-wide dcache transactions,
// doing read-modify-write for SB/SH and extending load data for writeback.
module lsu #(
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ex_valid,
  input  logic              ex_load,
  input  logic              ex_store,
  input  logic [2:0]        ex_funct3,
  input  logic [31:0]       ex_addr,
  input  logic [31:0]       ex_wdata,
  input  logic [4:0]        ex_rd_idx,
  output logic              stall,
  output logic              wb_valid,
  output logic [4:0]        wb_rd_idx,
  output logic [31:0]       wb_data,
  output logic              mem_done,
  output logic              fault,
  output logic [ADDR_W-1:0] c_address,
  output logic [31:0]       c_data,
  output logic              c_rd,
  output logic [3:0]        c_wr,
  input  logic              c_data_ready,
  input  logic [31:0]       c_data2cpu
);

  typedef enum logic [2:0] {IDLE, LD, RMW_RD, RMW_WR, ST, DONE} state_t;

  state_t            state, state_nx;
  logic [2:0]        f3_q, f3_nx;
  logic [1:0]        off_q, off_nx;
  logic [31:0]       wdata_q, wdata_nx;
  logic [4:0]        rd_q, rd_nx;

  logic              c_rd_nx;
  logic [3:0]        c_wr_nx;
  logic [31:0]       c_data_nx;
  logic [ADDR_W-1:0] c_address_nx;
  logic              wb_valid_nx;
  logic [4:0]        wb_rd_idx_nx;
  logic [31:0]       wb_data_nx;
  logic              mem_done_nx;
  logic              fault_nx;

  logic              f3_ok;
  logic              misaligned;
  logic              req_fault;
  logic [31:0]       lane_word;
  logic [31:0]       load_val;
  logic [31:0]       merged;

  // Address bits above the cache window are intentionally dropped.
  logic unused_addr_hi;
  assign unused_addr_hi = ^ex_addr[31:ADDR_W];

  always_comb begin
    f3_ok = 1'b0;
    case (ex_funct3)
      3'b000, 3'b001, 3'b010: f3_ok = 1'b1;
      3'b100, 3'b101:         f3_ok = ex_load;
      default:                f3_ok = 1'b0;
    endcase
    misaligned = ((ex_funct3[1:0] == 2'b01) && ex_addr[0]) ||
                 ((ex_funct3[1:0] == 2'b10) && (ex_addr[1:0] != 2'b00));
    req_fault  = (ex_load == ex_store) || !f3_ok || misaligned;
  end

  always_comb begin
    lane_word = c_data2cpu >> {off_q, 3'b000};
    case (f3_q)
      3'b000:  load_val = {{24{lane_word[7]}}, lane_word[7:0]};
      3'b001:  load_val = {{16{lane_word[15]}}, lane_word[15:0]};
      3'b100:  load_val = {24'b0, lane_word[7:0]};
      3'b101:  load_val = {16'b0, lane_word[15:0]};
      default: load_val = c_data2cpu;
    endcase
  end

  always_comb begin
    merged = c_data2cpu;
    if (f3_q[1:0] == 2'b00) begin
      merged[{off_q, 3'b000} +: 8] = wdata_q[7:0];
    end else begin
      merged[{off_q[1], 4'b0000} +: 16] = wdata_q[15:0];
    end
  end

  assign stall = !rst && (((state != IDLE) && (state != DONE)) ||
                          ((state == IDLE) && ex_valid && !req_fault));

  always_comb begin
    state_nx     = state;
    f3_nx        = f3_q;
    off_nx       = off_q;
    wdata_nx     = wdata_q;
    rd_nx        = rd_q;
    c_rd_nx      = c_rd;
    c_wr_nx      = c_wr;
    c_data_nx    = c_data;
    c_address_nx = c_address;
    wb_valid_nx  = 1'b0;
    wb_rd_idx_nx = wb_rd_idx;
    wb_data_nx   = wb_data;
    mem_done_nx  = 1'b0;
    fault_nx     = 1'b0;

    case (state)
      IDLE: begin
        if (ex_valid) begin
          if (req_fault) begin
            fault_nx = 1'b1;
          end else begin
            f3_nx        = ex_funct3;
            off_nx       = ex_addr[1:0];
            wdata_nx     = ex_wdata;
            rd_nx        = ex_rd_idx;
            c_address_nx = {ex_addr[ADDR_W-1:2], 2'b00};
            if (ex_load) begin
              c_rd_nx  = 1'b1;
              state_nx = LD;
            end else if (ex_funct3 == 3'b010) begin
              c_wr_nx   = '1;
              c_data_nx = ex_wdata;
              state_nx  = ST;
            end else begin
              c_rd_nx  = 1'b1;
              state_nx = RMW_RD;
            end
          end
        end
      end
      LD: begin
        if (c_data_ready) begin
          c_rd_nx      = 1'b0;
          wb_valid_nx  = 1'b1;
          wb_data_nx   = load_val;
          wb_rd_idx_nx = rd_q;
          mem_done_nx  = 1'b1;
          state_nx     = DONE;
        end
      end
      RMW_RD: begin
        // Read half done: the write request goes out on the same edge the read drops.
        if (c_data_ready) begin
          c_rd_nx   = 1'b0;
          c_wr_nx   = '1;
          c_data_nx = merged;
          state_nx  = RMW_WR;
        end
      end
      RMW_WR, ST: begin
        if (c_data_ready) begin
          c_wr_nx     = '0;
          mem_done_nx = 1'b1;
          state_nx    = DONE;
        end
      end
      DONE: begin
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      f3_q      <= '0;
      off_q     <= '0;
      wdata_q   <= '0;
      rd_q      <= '0;
      c_rd      <= 1'b0;
      c_wr      <= '0;
      c_data    <= '0;
      c_address <= '0;
      wb_valid  <= 1'b0;
      wb_rd_idx <= '0;
      wb_data   <= '0;
      mem_done  <= 1'b0;
      fault     <= 1'b0;
    end else begin
      state     <= state_nx;
      f3_q      <= f3_nx;
      off_q     <= off_nx;
      wdata_q   <= wdata_nx;
      rd_q      <= rd_nx;
      c_rd      <= c_rd_nx;
      c_wr      <= c_wr_nx;
      c_data    <= c_data_nx;
      c_address <= c_address_nx;
      wb_valid  <= wb_valid_nx;
      wb_rd_idx <= wb_rd_idx_nx;
      wb_data   <= wb_data_nx;
      mem_done  <= mem_done_nx;
      fault     <= fault_nx;
    end
  end

endmodule

// File: tb/tb_lsu.sv
// Bench for lsu: behavioural word cache with configurable latency, plus a
// reference model of load extraction, store merging and cycle timing.
module tb_lsu;

  localparam int ADDR_W = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic              ex_valid, ex_load, ex_store;
  logic [2:0]        ex_funct3;
  logic [31:0]       ex_addr, ex_wdata;
  logic [4:0]        ex_rd_idx;
  logic              stall, wb_valid, mem_done, fault;
  logic [4:0]        wb_rd_idx;
  logic [31:0]       wb_data;
  logic [ADDR_W-1:0] c_address;
  logic [31:0]       c_data;
  logic              c_rd;
  logic [3:0]        c_wr;
  logic              c_data_ready;
  logic [31:0]       c_data2cpu;

  always #5 clk = ~clk;

  lsu #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst),
    .ex_valid(ex_valid), .ex_load(ex_load), .ex_store(ex_store),
    .ex_funct3(ex_funct3), .ex_addr(ex_addr), .ex_wdata(ex_wdata),
    .ex_rd_idx(ex_rd_idx),
    .stall(stall), .wb_valid(wb_valid), .wb_rd_idx(wb_rd_idx),
    .wb_data(wb_data), .mem_done(mem_done), .fault(fault),
    .c_address(c_address), .c_data(c_data), .c_rd(c_rd), .c_wr(c_wr),
    .c_data_ready(c_data_ready), .c_data2cpu(c_data2cpu)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Cache model: seed[] holds initial contents (bench-owned), cmem/written
  // hold what the LSU has written (model-owned).
  logic [31:0] seed    [0:16383];
  logic [31:0] rmem    [0:16383];
  logic [31:0] cmem    [0:16383];
  bit          written [0:16383];
  int lat  = 1;
  int cnt  = 0;
  int n_rd = 0;
  int n_wr = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      c_data_ready <= 1'b0;
      c_data2cpu   <= '0;
      cnt = 0;
    end else if (c_data_ready) begin
      c_data_ready <= 1'b0;
      cnt = 0;
    end else if (c_rd || (c_wr != 4'b0000)) begin
      cnt = cnt + 1;
      if (cnt >= lat) begin
        c_data_ready <= 1'b1;
        cnt = 0;
        if (c_rd) begin
          c_data2cpu <= written[c_address[ADDR_W-1:2]] ? cmem[c_address[ADDR_W-1:2]]
                                                      : seed[c_address[ADDR_W-1:2]];
          n_rd++;
        end else begin
          cmem[c_address[ADDR_W-1:2]]    <= c_data;
          written[c_address[ADDR_W-1:2]] <= 1'b1;
          n_wr++;
        end
      end
    end
  end

  function automatic bit is_legal(input bit ld, input bit st, input logic [2:0] f3,
                                  input logic [31:0] a);
    if (ld == st) return 1'b0;
    case (f3)
      3'b000: return 1'b1;
      3'b100: return ld;
      3'b001: return (a % 2) == 0;
      3'b101: return ld && ((a % 2) == 0);
      3'b010: return (a % 4) == 0;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] ref_load(input logic [31:0] w, input logic [2:0] f3,
                                           input int off);
    logic [31:0] b, h;
    b = (w >> (8 * off)) & 32'hFF;
    h = (w >> (8 * off)) & 32'hFFFF;
    case (f3)
      3'b000:  return (b >= 128) ? b + 32'hFFFFFF00 : b;
      3'b001:  return (h >= 32768) ? h + 32'hFFFF0000 : h;
      3'b100:  return b;
      3'b101:  return h;
      default: return w;
    endcase
  endfunction

  function automatic logic [31:0] ref_store(input logic [31:0] w, input logic [2:0] f3,
                                            input int off, input logic [31:0] d);
    logic [31:0] mask;
    if (f3 == 3'b010) return d;
    mask = (f3 == 3'b000) ? 32'hFF : 32'hFFFF;
    mask = mask << (8 * off);
    return (w & ~mask) | ((d << (8 * off)) & mask);
  endfunction

  logic [31:0] last_wb;

  task automatic run_op(input bit ld, input bit st, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [4:0] rd, input string tag);
    bit legal, sub;
    int wa, off, exp_done, exp_req, limit;
    int done_cyc, wb_cyc, fault_cyc, req_cyc, stall_err, addr_err, wr_err;
    int rd0, wr0;
    logic [31:0] exp_val, wb_seen;
    logic [4:0]  wb_rd_seen;

    legal    = is_legal(ld, st, f3, addr);
    sub      = st && (f3 != 3'b010);
    wa       = int'((addr >> 2) & 32'h3FFF);
    off      = int'(addr & 32'h3);
    exp_val  = ref_load(rmem[wa], f3, off);
    exp_done = sub ? 2 * lat + 3 : lat + 2;
    exp_req  = sub ? 2 * lat + 2 : lat + 1;
    limit    = 2 * lat + 12;
    done_cyc = -1; wb_cyc = -1; fault_cyc = -1;
    req_cyc  = 0; stall_err = 0; addr_err = 0; wr_err = 0;
    wb_seen  = '0; wb_rd_seen = '0;
    rd0 = n_rd; wr0 = n_wr;

    @(negedge clk);
    ex_valid = 1'b1; ex_load = ld; ex_store = st; ex_funct3 = f3;
    ex_addr = addr; ex_wdata = wdata; ex_rd_idx = rd;
    #1;
    check({tag, "_stall0"}, {31'b0, stall}, {31'b0, legal});
    @(posedge clk); #1;
    ex_valid = 1'b0; ex_load = 1'($urandom); ex_store = 1'($urandom);
    ex_funct3 = 3'($urandom); ex_addr = $urandom; ex_wdata = $urandom;
    ex_rd_idx = 5'($urandom);

    for (int k = 1; k <= limit; k++) begin
      if (c_rd || (c_wr != 4'b0000)) begin
        req_cyc++;
        if (c_address !== 16'(addr & 32'hFFFC)) addr_err++;
        if ((c_wr != 4'b0000) && (c_wr != 4'b1111)) wr_err++;
      end
      if (stall !== ((legal && (k < exp_done)) ? 1'b1 : 1'b0)) stall_err++;
      if (wb_valid && (wb_cyc < 0)) begin
        wb_cyc = k; wb_seen = wb_data; wb_rd_seen = wb_rd_idx;
      end
      if (mem_done && (done_cyc < 0)) done_cyc = k;
      if (fault && (fault_cyc < 0)) fault_cyc = k;
      if (legal && (done_cyc >= 0)) break;
      if (!legal && (k >= 3)) break;
      @(posedge clk); #1;
    end

    check({tag, "_stall"}, stall_err, 0);
    check({tag, "_addr"}, addr_err, 0);
    check({tag, "_wrmask"}, wr_err, 0);
    if (!legal) begin
      check({tag, "_fault_cyc"}, fault_cyc, 1);
      check({tag, "_no_req"}, req_cyc, 0);
      check({tag, "_no_txn"}, (n_rd - rd0) + (n_wr - wr0), 0);
    end else begin
      check({tag, "_fault"}, fault_cyc, -1);
      check({tag, "_done_cyc"}, done_cyc, exp_done);
      check({tag, "_req_cyc"}, req_cyc, exp_req);
      check({tag, "_reads"}, n_rd - rd0, st && !sub ? 0 : 1);
      check({tag, "_writes"}, n_wr - wr0, st ? 1 : 0);
      if (ld) begin
        check({tag, "_wb_cyc"}, wb_cyc, exp_done);
        check({tag, "_wb_data"}, wb_seen, exp_val);
        check({tag, "_wb_rd"}, {27'b0, wb_rd_seen}, {27'b0, rd});
        last_wb = wb_seen;
      end else begin
        check({tag, "_no_wb"}, wb_cyc, -1);
        rmem[wa] = ref_store(rmem[wa], f3, off, wdata);
        check({tag, "_mem"}, cmem[wa], rmem[wa]);
      end
    end
    @(posedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    bit ld, st;
    int op;
    logic [2:0]  f3;
    logic [31:0] a;

    for (int i = 0; i < 16384; i++) begin
      seed[i] = $urandom;
      rmem[i] = seed[i];
    end
    rst = 1'b1; ex_valid = 1'b0; ex_load = 1'b0; ex_store = 1'b0;
    ex_funct3 = '0; ex_addr = '0; ex_wdata = '0; ex_rd_idx = '0;
    #12;
    check("reset_outs", {31'b0, |{c_rd, c_wr, c_data, c_address, wb_valid,
                                   wb_rd_idx, wb_data, mem_done, fault, stall}}, 0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk);

    // Load hits, T=1
    lat = 1;
    seed[16'h0104 >> 2] = 32'h8001F0A5; rmem[16'h0104 >> 2] = 32'h8001F0A5;
    run_op(1, 0, 3'b000, 32'h0104, 0, 5'd3, "lb");
    check("lb_const", last_wb, 32'hFFFFFFA5);
    run_op(1, 0, 3'b100, 32'h0107, 0, 5'd4, "lbu");
    check("lbu_const", last_wb, 32'h00000080);
    run_op(1, 0, 3'b001, 32'h0106, 0, 5'd5, "lh");
    check("lh_const", last_wb, 32'hFFFF8001);
    run_op(1, 0, 3'b010, 32'h0104, 0, 5'd6, "lw");
    check("lw_const", last_wb, 32'h8001F0A5);

    // Load miss, T=13
    lat = 13;
    run_op(1, 0, 3'b010, 32'h0200, 0, 5'd7, "lw_miss");

    // Sub-word store read-modify-write
    lat = 1;
    seed[16'h0104 >> 2] = 32'h11223344; rmem[16'h0104 >> 2] = 32'h11223344;
    run_op(0, 1, 3'b000, 32'h0105, 32'h000000AB, 5'd0, "sb");
    check("sb_const", cmem[16'h0104 >> 2], 32'h1122AB44);

    t0 = n_rd + n_wr;
    run_op(0, 1, 3'b001, 32'h0302, 32'h0000BEEF, 5'd0, "sh");
    run_op(0, 1, 3'b010, 32'h0300, 32'hCAFEBABE, 5'd0, "sw");
    check("shsw_const", cmem[16'h0300 >> 2], 32'hCAFEBABE);
    check("shsw_txn", n_rd + n_wr - t0, 3);

    // Faulting requests
    run_op(1, 0, 3'b010, 32'h0102, 0, 5'd1, "lw_mis");
    run_op(1, 1, 3'b010, 32'h0100, 0, 5'd1, "ld_st");

    // Reset while the RMW read is outstanding
    lat = 13;
    @(negedge clk);
    ex_valid = 1'b1; ex_load = 1'b0; ex_store = 1'b1; ex_funct3 = 3'b000;
    ex_addr = 32'h0400; ex_wdata = 32'h5A; ex_rd_idx = 5'd0;
    @(negedge clk); ex_valid = 1'b0;
    repeat (3) @(negedge clk);
    ex_valid = 1'b1; ex_load = 1'b1; ex_store = 1'b0; ex_funct3 = 3'b010;
    #2 rst = 1'b1;
    #1;
    check("rst_mid_outs", {31'b0, |{c_rd, c_wr, c_data, c_address, wb_valid,
                                     wb_rd_idx, wb_data, mem_done, fault}}, 0);
    check("rst_mid_stall", {31'b0, stall}, 0);
    ex_valid = 1'b0;
    @(negedge clk); rst = 1'b0;
    @(posedge clk);
    run_op(1, 0, 3'b010, 32'h0400, 0, 5'd9, "lw_after_rst");

    // Randomized mix
    for (int n = 0; n < 60; n++) begin
      lat = $urandom_range(1, 4);
      op  = $urandom_range(0, 7);
      case (op)
        0: f3 = 3'b000; 1: f3 = 3'b001; 2: f3 = 3'b010; 3: f3 = 3'b100;
        4: f3 = 3'b101; 5: f3 = 3'b000; 6: f3 = 3'b001; default: f3 = 3'b010;
      endcase
      ld = (op < 5);
      st = !ld;
      a  = $urandom_range(0, 16'hFFFF);
      if ($urandom_range(0, 9) != 0) begin
        if (f3[1:0] == 2'b01) a = a & ~32'h1;
        if (f3[1:0] == 2'b10) a = a & ~32'h3;
      end
      if ($urandom_range(0, 14) == 0) begin
        ld = 1'($urandom); st = ld;
      end
      if ($urandom_range(0, 19) == 0) f3 = 3'($urandom);
      run_op(ld, st, f3, a, $urandom, 5'($urandom), $sformatf("rnd%0d", n));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
